// File: rtl/pc_sequencer.sv
// pc_sequencer: decides each cycle whether the PC holds, steps or jumps.
// Ports: clock/reset; stall; jump_valid/jump_target; branch_taken/
// branch_target; exception; imem_ready -> pc_enable/pc_goto/pc_addr,
// imem_request, flush_if/flush_id, fetch_timeout.
module pc_sequencer #(
    parameter int                  BitWidth        = 32,
    parameter logic [BitWidth-1:0] ExceptionVector = 32'h0000_0180,
    parameter int                  FetchTimeout    = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                jump_valid,
    input  logic [BitWidth-1:0] jump_target,
    input  logic                branch_taken,
    input  logic [BitWidth-1:0] branch_target,
    input  logic                exception,
    input  logic                imem_ready,
    output logic                pc_enable,
    output logic                pc_goto,
    output logic [BitWidth-1:0] pc_addr,
    output logic                imem_request,
    output logic                flush_if,
    output logic                flush_id,
    output logic                fetch_timeout
);

    localparam int CntW = $clog2(FetchTimeout + 1);

    // Redirect kinds, encoded so that a larger value wins.
    localparam logic [1:0] KNone = 2'd0;
    localparam logic [1:0] KJmp  = 2'd1;
    localparam logic [1:0] KBr   = 2'd2;
    localparam logic [1:0] KExc  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    state_t              state;
    logic                pending_valid;
    logic [1:0]          pending_kind;
    logic [BitWidth-1:0] pending_addr;
    logic [CntW-1:0]     wait_cnt;

    logic [1:0]          cur_kind;
    logic [BitWidth-1:0] cur_addr;
    logic [1:0]          pend_kind;
    logic [1:0]          eff_kind;
    logic [BitWidth-1:0] eff_addr;
    logic                redirect;
    logic                timeout_hit;
    logic                capture;

    // Highest-priority redirect on the inputs this cycle.
    always_comb begin
        cur_kind = KNone;
        cur_addr = '0;
        if (exception) begin
            cur_kind = KExc;
            cur_addr = ExceptionVector;
        end else if (branch_taken) begin
            cur_kind = KBr;
            cur_addr = branch_target;
        end else if (jump_valid) begin
            cur_kind = KJmp;
            cur_addr = jump_target;
        end
    end

    // Current input beats pending on equal priority.
    always_comb begin
        pend_kind = pending_valid ? pending_kind : KNone;
        if (cur_kind >= pend_kind) begin
            eff_kind = cur_kind;
            eff_addr = cur_addr;
        end else begin
            eff_kind = pend_kind;
            eff_addr = pending_addr;
        end
        redirect    = (eff_kind != KNone);
        timeout_hit = (state == FETCH) && !imem_ready &&
                      (wait_cnt == CntW'(FetchTimeout));
        capture     = (cur_kind != KNone) && (cur_kind >= pend_kind);
    end

    // Outputs are forced low while reset is held so that a pending
    // redirect or timeout cannot leak out in the reset cycle.
    always_comb begin
        pc_enable     = 1'b0;
        pc_goto       = 1'b0;
        pc_addr       = '0;
        imem_request  = 1'b0;
        flush_if      = 1'b0;
        flush_id      = 1'b0;
        fetch_timeout = 1'b0;
        if (!reset) begin
            unique case (state)
                FETCH: begin
                    imem_request = 1'b1;
                    if (!imem_ready) begin
                        if (timeout_hit) begin
                            fetch_timeout = 1'b1;
                            pc_enable     = 1'b1;
                            pc_goto       = 1'b1;
                            pc_addr       = ExceptionVector;
                            flush_if      = 1'b1;
                        end
                    end else if (redirect) begin
                        pc_enable = 1'b1;
                        pc_goto   = 1'b1;
                        pc_addr   = eff_addr;
                        flush_if  = 1'b1;
                        flush_id  = (eff_kind == KExc) || (eff_kind == KBr);
                    end else if (!stall) begin
                        pc_enable = 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_enable = 1'b1;
                        pc_goto   = 1'b1;
                        pc_addr   = eff_addr;
                        flush_if  = 1'b1;
                        flush_id  = (eff_kind == KExc) || (eff_kind == KBr);
                    end else if (!stall) begin
                        pc_enable = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            pending_valid <= 1'b0;
            pending_kind  <= KNone;
            pending_addr  <= '0;
            wait_cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= FETCH;
                    wait_cnt <= '0;
                end
                FETCH: begin
                    if (!imem_ready) begin
                        if (timeout_hit) begin
                            pending_valid <= 1'b0;
                            pending_kind  <= KNone;
                            pending_addr  <= '0;
                            wait_cnt      <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                            if (capture) begin
                                pending_valid <= 1'b1;
                                pending_kind  <= cur_kind;
                                pending_addr  <= cur_addr;
                            end
                        end
                    end else begin
                        pending_valid <= 1'b0;
                        pending_kind  <= KNone;
                        pending_addr  <= '0;
                        wait_cnt      <= '0;
                        if (!redirect && stall) state <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect || !stall) state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer.
// Expected outputs are queued per step and compared before the next edge.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exception;
    logic        imem_ready;
    logic        pc_enable;
    logic        pc_goto;
    logic [31:0] pc_addr;
    logic        imem_request;
    logic        flush_if;
    logic        flush_id;
    logic        fetch_timeout;

    logic [31:0] pc;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        en;
        logic        go;
        logic [31:0] addr;
        logic        req;
        logic        fif;
        logic        fid;
        logic        to;
    } out_t;

    out_t sb[$];

    pc_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .jump_valid   (jump_valid),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .exception    (exception),
        .imem_ready   (imem_ready),
        .pc_enable    (pc_enable),
        .pc_goto      (pc_goto),
        .pc_addr      (pc_addr),
        .imem_request (imem_request),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .fetch_timeout(fetch_timeout)
    );

    always #5 clock = ~clock;

    // Reference PC register driven by the sequencer outputs.
    always @(posedge clock) begin
        if (reset) pc <= 32'h0;
        else if (pc_enable) pc <= pc_goto ? pc_addr : pc + 32'd4;
    end

    task automatic setin(input logic r, input logic st,
                         input logic jv, input logic [31:0] jt,
                         input logic bt, input logic [31:0] btg,
                         input logic ex, input logic rdy);
        reset         = r;
        stall         = st;
        jump_valid    = jv;
        jump_target   = jt;
        branch_taken  = bt;
        branch_target = btg;
        exception     = ex;
        imem_ready    = rdy;
    endtask

    // Push expectation, compare mid-cycle, advance to next negedge.
    task automatic cyc(input string tag, input logic en, input logic go,
                       input logic [31:0] addr, input logic req,
                       input logic fif, input logic fid, input logic to);
        out_t e;
        out_t o;
        e = '{en, go, addr, req, fif, fid, to};
        sb.push_back(e);
        #1;
        o = '{pc_enable, pc_goto, pc_addr, imem_request,
              flush_if, flush_id, fetch_timeout};
        e = sb.pop_front();
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
        @(negedge clock);
    endtask

    task automatic check_pc(input string tag, input logic [31:0] v);
        checks++;
        assert (pc === v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, pc, v);
        end
    endtask

    initial begin
        setin(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        cyc("reset", 0, 0, 0, 0, 0, 0, 0);

        setin(0, 0, 0, 0, 0, 0, 0, 1);
        cyc("idle", 0, 0, 0, 0, 0, 0, 0);
        check_pc("pc0", 32'h0);
        cyc("seq0", 1, 0, 0, 1, 0, 0, 0);
        check_pc("pc4", 32'h4);
        cyc("seq1", 1, 0, 0, 1, 0, 0, 0);
        check_pc("pc8", 32'h8);

        setin(0, 1, 0, 0, 0, 0, 0, 1);
        cyc("stall_rdy", 0, 0, 0, 1, 0, 0, 0);
        cyc("hold1", 0, 0, 0, 0, 0, 0, 0);
        cyc("hold2", 0, 0, 0, 0, 0, 0, 0);
        cyc("hold3", 0, 0, 0, 0, 0, 0, 0);
        check_pc("pc_hold", 32'h8);
        setin(0, 0, 0, 0, 0, 0, 0, 1);
        cyc("unstall", 1, 0, 0, 0, 0, 0, 0);
        check_pc("pc12", 32'hc);

        setin(0, 0, 0, 0, 1, 32'h100, 0, 0);
        cyc("br_wait1", 0, 0, 0, 1, 0, 0, 0);
        cyc("br_wait2", 0, 0, 0, 1, 0, 0, 0);
        setin(0, 0, 0, 0, 0, 0, 0, 1);
        cyc("br_apply", 1, 1, 32'h100, 1, 1, 1, 0);
        check_pc("pc_br", 32'h100);

        setin(0, 0, 1, 32'h40, 0, 0, 0, 0);
        cyc("jmp_wait", 0, 0, 0, 1, 0, 0, 0);
        setin(0, 0, 0, 0, 0, 0, 1, 1);
        cyc("exc_win", 1, 1, 32'h180, 1, 1, 1, 0);
        setin(0, 0, 0, 0, 0, 0, 0, 1);
        cyc("jmp_gone", 1, 0, 0, 1, 0, 0, 0);
        check_pc("pc_exc", 32'h184);

        setin(0, 0, 0, 0, 1, 32'h200, 0, 0);
        cyc("br_pend", 0, 0, 0, 1, 0, 0, 0);
        setin(0, 0, 1, 32'h300, 0, 0, 0, 1);
        cyc("br_over_jmp", 1, 1, 32'h200, 1, 1, 1, 0);
        check_pc("pc_br2", 32'h200);

        setin(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc("to_wait", 0, 0, 0, 1, 0, 0, 0);
        cyc("to_pulse", 1, 1, 32'h180, 1, 1, 0, 1);
        cyc("to_after", 0, 0, 0, 1, 0, 0, 0);
        check_pc("pc_to", 32'h180);

        setin(0, 0, 0, 0, 1, 32'h500, 0, 0);
        cyc("rst_pend", 0, 0, 0, 1, 0, 0, 0);
        setin(1, 0, 0, 0, 0, 0, 0, 1);
        cyc("rst_assert", 0, 0, 0, 0, 0, 0, 0);
        cyc("rst_held", 0, 0, 0, 0, 0, 0, 0);
        setin(0, 0, 0, 0, 0, 0, 0, 1);
        cyc("rst_idle", 0, 0, 0, 0, 0, 0, 0);
        check_pc("pc_rst", 32'h0);
        cyc("rst_seq", 1, 0, 0, 1, 0, 0, 0);
        check_pc("pc_rst4", 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
